// File: rtl/divider_pkg.sv
// Shared types and constants for the sequential signed divider.
// Used by divider_seq in both builds (DIVIDER_EARLY_OUT_EN defined or not).
package divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int MAX_W = 64;

  // Quotient pattern reported for a zero divisor (-1 at any width up to MAX_W).
  localparam logic [MAX_W-1:0] DZ_QUO = '1;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/divider_step.sv
// One restoring radix-2 iteration: shift {rem, quo} left, trial-subtract dvs,
// keep the difference and set the quotient bit when it is non-negative.
module divider_step #(
  parameter int W = 32
) (
  input  logic [W:0]   rem,
  input  logic [W-1:0] quo,
  input  logic [W:0]   dvs,
  output logic [W:0]   rem_next,
  output logic [W-1:0] quo_next
);

  logic [W+1:0] rem_sh;
  logic [W+1:0] diff;
  logic         nonneg;

  // One guard bit above the partial remainder makes the sign test exact.
  assign rem_sh = {rem, quo[W-1]};
  assign diff   = rem_sh - {1'b0, dvs};
  assign nonneg = ~diff[W+1];

  always_comb begin
    quo_next = {quo[W-2:0], nonneg};
    rem_next = nonneg ? diff[W:0] : rem_sh[W:0];
  end

endmodule

// File: rtl/divider_seq.sv
// Iterative signed divider (restoring, one quotient bit per clock), W+2 cycle latency.
// Defining DIVIDER_EARLY_OUT_EN lets trivial operands finish in one cycle.
module divider_seq
  import divider_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder,
  output logic         div_by_zero
);

  localparam int CW = clog2(W + 1);

  // Handshake: start is sampled only in IDLE; busy is high from the cycle
  // after acceptance through the done cycle; done is a one-cycle pulse and
  // the result outputs hold until the next result is registered.

  state_t         state;
  logic [CW-1:0]  cnt;
  logic [W:0]     rem_q;
  logic [W-1:0]   quo_q;
  logic [W:0]     dvs_q;
  logic           sign_q;
  logic           sign_r;
  logic           dz_q;

  logic [W:0]     rem_nx;
  logic [W-1:0]   quo_nx;
  logic [W-1:0]   dvd_abs;
  logic [W:0]     dvs_ext;
  logic [W:0]     dvs_abs;
  logic [W-1:0]   quo_fix;
  logic [W-1:0]   rem_fix;

  divider_step #(.W(W)) u_step (
    .rem      (rem_q),
    .quo      (quo_q),
    .dvs      (dvs_q),
    .rem_next (rem_nx),
    .quo_next (quo_nx)
  );

  // |-2^(W-1)| wraps to 2^(W-1), which is still correct read as unsigned.
  always_comb begin
    dvd_abs = dividend[W-1] ? (-dividend) : dividend;
    dvs_ext = {divisor[W-1], divisor};
    dvs_abs = divisor[W-1] ? (-dvs_ext) : dvs_ext;
    quo_fix = sign_q ? (-quo_q) : quo_q;
    rem_fix = sign_r ? (-rem_q[W-1:0]) : rem_q[W-1:0];
  end

`ifdef DIVIDER_EARLY_OUT_EN
  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  logic         triv;
  logic [W-1:0] triv_quo;
  logic [W-1:0] triv_rem;

  always_comb begin
    triv     = 1'b1;
    triv_quo = '0;
    triv_rem = '0;
    if (divisor == '0) begin
      triv_quo = DZ_QUO[W-1:0];
      triv_rem = dividend;
    end else if (dividend == '0) begin
      triv_quo = '0;
    end else if (divisor == ONE) begin
      triv_quo = dividend;
    end else if (divisor == '1) begin
      triv_quo = -dividend;
    end else begin
      triv = 1'b0;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      sign_q      <= 1'b0;
      sign_r      <= 1'b0;
      dz_q        <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy   <= 1'b1;
            sign_q <= dividend[W-1] ^ divisor[W-1];
            sign_r <= dividend[W-1];
            dz_q   <= (divisor == '0);
            dvs_q  <= dvs_abs;
            rem_q  <= '0;
            quo_q  <= dvd_abs;
            cnt    <= '0;
            state  <= CALC;
`ifdef DIVIDER_EARLY_OUT_EN
            // Trivial operands load the final result and bypass the iterations.
            if (triv) begin
              quo_q <= triv_quo;
              rem_q <= {1'b0, triv_rem};
              state <= FIX;
            end
`endif
          end
        end
        CALC: begin
          // After the W-th iteration one more cycle applies the sign correction.
          if (cnt == CW'(W)) begin
            quo_q <= dz_q ? DZ_QUO[W-1:0] : quo_fix;
            rem_q <= {1'b0, rem_fix};
            state <= FIX;
          end else begin
            rem_q <= rem_nx;
            quo_q <= quo_nx;
            cnt   <= cnt + 1'b1;
          end
        end
        FIX: begin
          quotient    <= quo_q;
          remainder   <= rem_q[W-1:0];
          div_by_zero <= dz_q;
          done        <= 1'b1;
          state       <= DONE;
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_divider_seq.sv
// Self-checking bench for divider_seq: directed cases, handshake corner cases
// and a random signed regression; latencies follow DIVIDER_EARLY_OUT_EN.
module tb_divider_seq;

  localparam int W   = 32;
  localparam int LAT = W + 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int n_checks = 0;
  int n_fail   = 0;

  // Scoreboard entries are {div_by_zero, quotient, remainder}.
  logic [2*W:0] exp_q[$];

  divider_seq #(.W(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_lat(input logic [W-1:0] a, input logic [W-1:0] b);
    int lat;
    lat = LAT;
`ifdef DIVIDER_EARLY_OUT_EN
    if (b == '0 || a == '0 || b == W'(1) || b == '1) lat = 1;
`endif
    return lat;
  endfunction

  // Reference: 64-bit signed arithmetic, truncating toward zero.
  function automatic logic [2*W:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa, sb;
    logic [63:0] q64, r64;
    if (b == '0) return {1'b1, {W{1'b1}}, a};
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    q64 = sa / sb;
    r64 = sa % sb;
    return {1'b0, q64[W-1:0], r64[W-1:0]};
  endfunction

  // ---------------- drivers ----------------
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [2*W:0] expv, input bit hold);
    @(negedge clk);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    exp_q.push_back(expv);
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
  endtask

  // Called just after the accepting edge; returns one cycle after done.
  task automatic wait_done(input string tag, input int lat, input int glitch_k);
    int k;
    bit seen;
    logic [2*W:0] e;
    k    = 0;
    seen = 1'b0;
    while (k <= 2 * LAT + 4) begin
      if (k == glitch_k) begin
        start    = 1'b1;
        dividend = $urandom;
        divisor  = W'(3);
      end else if (k == glitch_k + 1) begin
        start = 1'b0;
      end
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      check({tag, " busy"}, busy, 1'b1);
      @(posedge clk);
      #1;
      k++;
    end
    check({tag, " done_seen"}, seen, 1'b1);
    if (seen) begin
      check({tag, " latency"}, k, lat);
      check({tag, " busy_at_done"}, busy, 1'b1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check({tag, " result"}, {div_by_zero, quotient, remainder}, e);
      end else begin
        check({tag, " scoreboard_empty"}, exp_q.size(), 1);
      end
      @(posedge clk);
      #1;
      check({tag, " done_pulse"}, done, 1'b0);
      check({tag, " busy_idle"}, busy, 1'b0);
    end
  endtask

  task automatic run(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic [W-1:0] eq, input logic [W-1:0] er, input logic edz);
    issue(a, b, {edz, eq, er}, 1'b0);
    wait_done(tag, exp_lat(a, b), -10);
  endtask

  // ---------------- sequence ----------------
  initial begin
    int hits;
    logic [W-1:0] a, b;

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset busy", busy, 1'b0);
    check("reset done", done, 1'b0);
    check("reset quotient", quotient, '0);
    check("reset remainder", remainder, '0);
    check("reset dz", div_by_zero, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    run("150/10", W'(150), W'(10), W'(15), W'(0), 1'b0);
    run("-300/12", W'(-300), W'(12), W'(-25), W'(0), 1'b0);
    run("-7/2", W'(-7), W'(2), W'(-3), W'(-1), 1'b0);
    run("7/-2", W'(7), W'(-2), W'(-3), W'(1), 1'b0);
    run("-8/-8", W'(-8), W'(-8), W'(1), W'(0), 1'b0);
    run("123/0", W'(123), W'(0), 32'hFFFF_FFFF, W'(123), 1'b1);
    run("min/-1", 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, W'(0), 1'b0);
    run("max/max", 32'h7FFF_FFFF, 32'h7FFF_FFFF, W'(1), W'(0), 1'b0);
    run("min/min", 32'h8000_0000, 32'h8000_0000, W'(1), W'(0), 1'b0);
    run("min/3", 32'h8000_0000, W'(3), W'(-715827882), W'(-2), 1'b0);

    // start pulsed mid-iteration must be ignored
    issue(W'(1000), W'(7), {1'b0, W'(142), W'(6)}, 1'b0);
    wait_done("glitch", LAT, 5);

    // start held through done: second op accepted only once back in IDLE
    issue(W'(-100), W'(9), {1'b0, W'(-11), W'(-1)}, 1'b1);
    dividend = W'(77);
    divisor  = W'(-5);
    wait_done("hold1", LAT, -10);
    exp_q.push_back({1'b0, W'(-15), W'(2)});
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done("hold2", LAT, -10);

    // asynchronous reset in the middle of CALC
    issue(W'(555), W'(5), {1'b0, W'(111), W'(0)}, 1'b0);
    repeat (10) begin
      @(posedge clk);
      #1;
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("abort busy", busy, 1'b0);
    check("abort done", done, 1'b0);
    check("abort quotient", quotient, '0);
    check("abort remainder", remainder, '0);
    check("abort dz", div_by_zero, 1'b0);
    void'(exp_q.pop_back());
    hits = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) hits++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (W + 4) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) hits++;
    end
    check("abort no_done", hits, 0);
    run("post_reset 42/-6", W'(42), W'(-6), W'(-7), W'(0), 1'b0);

    // trivial operands (one-cycle latency when early-out is built in)
    run("0/5", W'(0), W'(5), W'(0), W'(0), 1'b0);
    run("9/1", W'(9), W'(1), W'(9), W'(0), 1'b0);
    run("9/-1", W'(9), W'(-1), W'(-9), W'(0), 1'b0);
    run("9/0", W'(9), W'(0), 32'hFFFF_FFFF, W'(9), 1'b1);

    // random signed regression
    for (int i = 0; i < 1200; i++) begin
      case ($urandom_range(0, 4))
        0: begin a = $urandom; b = $urandom; end
        1: begin a = $urandom; b = W'($urandom_range(0, 20)) - W'(10); end
        2: begin a = W'($urandom_range(0, 2000)) - W'(1000); b = W'($urandom_range(0, 40)) - W'(20); end
        3: begin a = ($urandom_range(0, 1) == 1) ? 32'h8000_0000 : 32'h7FFF_FFFF; b = $urandom; end
        default: begin a = $urandom >> $urandom_range(0, 31); b = $urandom >> $urandom_range(0, 31); end
      endcase
      issue(a, b, model(a, b), 1'b0);
      wait_done("random", exp_lat(a, b), -10);
      if (b != '0) check("random identity", W'(quotient * divisor + remainder), a);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
